// File: rtl/toy_hash_pkg.sv
// rtl/toy_hash_pkg.sv - shared types, default constants and round function for toy_hash_core
package toy_hash_pkg;

  localparam int HW_MAX = 64;

  typedef logic [HW_MAX-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    word_t c;
    word_t b;
    word_t a;
  } abc_t;

  localparam word_t IV0_DEF = 64'h01;
  localparam word_t IV1_DEF = 64'h89;
  localparam word_t IV2_DEF = 64'hFE;
  localparam word_t K1_DEF  = 64'h99;
  localparam word_t K2_DEF  = 64'hA1;

  // Works on full-width words; callers keep the low W bits, which is exact
  // because every operation here only propagates carries/shifts upward.
  function automatic abc_t round_fn(input word_t a, input word_t b, input word_t c,
                                    input word_t w, input logic late,
                                    input word_t k1, input word_t k2,
                                    input int unsigned shift);
    abc_t  r;
    word_t f;
    word_t k;
    f   = late ? (a | b) : (a ^ b);
    k   = late ? k2 : k1;
    r.a = b ^ c;
    r.b = c << shift;
    r.c = f + k + w;
    return r;
  endfunction

endpackage

// File: rtl/toy_hash_sched.sv
// rtl/toy_hash_sched.sv - message schedule shift window with on-the-fly expansion
module toy_hash_sched #(
  parameter int W         = 8,
  parameter int MSG_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic [MSG_WORDS*W-1:0] load_data,
  output logic [W-1:0]           w0
);

  logic [MSG_WORDS-1:0][W-1:0] win;
  logic [W-1:0]                fb;

  // Relative to the current round t this is W[t+16] = W[t+13] | (W[t+7] ^ W[t+2]).
  assign fb = win[MSG_WORDS-3] | (win[MSG_WORDS-9] ^ win[MSG_WORDS-14]);
  assign w0 = win[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      win <= '0;
    end else if (load) begin
      win <= load_data;
    end else if (shift) begin
      win <= {fb, win[MSG_WORDS-1:1]};
    end
  end

endmodule

// File: rtl/toy_hash_core.sv
// rtl/toy_hash_core.sv - handshaked multi-round 3-word toy hash; TOY_HASH_B2B_EN enables DONE->ROUND chaining
module toy_hash_core
  import toy_hash_pkg::*;
#(
  parameter int    W         = 8,
  parameter int    MSG_WORDS = 16,
  parameter int    ROUNDS    = 32,
  parameter int    SHIFT     = 4,
  parameter word_t IV0       = IV0_DEF,
  parameter word_t IV1       = IV1_DEF,
  parameter word_t IV2       = IV2_DEF,
  parameter word_t K1        = K1_DEF,
  parameter word_t K2        = K2_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic [MSG_WORDS*W-1:0] in_msg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3*W-1:0]         out_hash,
  output logic                   busy
);

  localparam int          CW          = $clog2(ROUNDS + 1);
  localparam logic [31:0] MSG_WORDS_U = MSG_WORDS;
  localparam logic [3*W-1:0] IV_W     = {IV2[W-1:0], IV1[W-1:0], IV0[W-1:0]};

  state_t          state, state_nxt;
  logic [CW-1:0]   t;
  logic [W-1:0]    a, b, c;
  logic [W-1:0]    init_a, init_b, init_c;
  logic [3*W-1:0]  chain;
  logic [3*W-1:0]  hash_q;
  logic [3*W-1:0]  init_sel;
  logic [3*W-1:0]  digest;
  logic [W-1:0]    w0;
  logic            load;
  logic            shift;
  logic            last;
  logic            late;
  abc_t            rnd;
  logic            unused_rnd;

  assign last     = (t == CW'(ROUNDS - 1));
  assign late     = (32'(t) >= MSG_WORDS_U);
  assign init_sel = in_first ? IV_W : chain;
  assign digest   = {c + init_c, b + init_b, a + init_a};
  assign rnd      = round_fn(word_t'(a), word_t'(b), word_t'(c), word_t'(w0),
                             late, K1, K2, SHIFT);
  assign unused_rnd = &{1'b0, rnd};

  assign out_valid = (state == DONE);
  assign out_hash  = hash_q;
  assign busy      = (state == ROUND) || (state == FINAL);

  toy_hash_sched #(
    .W         (W),
    .MSG_WORDS (MSG_WORDS)
  ) u_sched (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (in_msg),
    .w0        (w0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        shift = 1'b1;
        if (last) begin
          state_nxt = FINAL;
        end
      end
      FINAL: begin
        state_nxt = DONE;
      end
      DONE: begin
`ifdef TOY_HASH_B2B_EN
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = ROUND;
          end else begin
            state_nxt = IDLE;
          end
        end
`else
        if (out_ready) begin
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // chain holds the last digest, so a DONE->ROUND reload chains from what is on out_hash.
  always_ff @(posedge clk) begin
    if (reset) begin
      a      <= '0;
      b      <= '0;
      c      <= '0;
      init_a <= '0;
      init_b <= '0;
      init_c <= '0;
      chain  <= IV_W;
      hash_q <= '0;
      t      <= '0;
    end else begin
      if (load) begin
        {c, b, a}              <= init_sel;
        {init_c, init_b, init_a} <= init_sel;
        t                      <= '0;
      end else if (state == ROUND) begin
        a <= rnd.a[W-1:0];
        b <= rnd.b[W-1:0];
        c <= rnd.c[W-1:0];
        if (!last) begin
          t <= t + 1'b1;
        end
      end
      if (state == FINAL) begin
        hash_q <= digest;
        chain  <= digest;
      end
    end
  end

endmodule

// File: doc/toy_hash_core.md
Name: toy_hash_core

Overview:
- Parametrised, handshaked successor of the 3-word toy hash datapath.
- Absorbs one MSG_WORDS-word block per transaction and runs ROUNDS compression rounds on a 3-word state (a, b, c), one round per cycle.
- Expands the message schedule on the fly and adds the block's initial chaining value to produce the digest.
- Supports multi-block messages via chaining; sits between the message packer and the digest consumer.

Parameters:
- W, 8, word width in bits (>=4).
- MSG_WORDS, 16, words per block (>=14).
- ROUNDS, 32, rounds per block (>=1; may be < MSG_WORDS).
- SHIFT, 4, left-shift amount in the b update (<W).
- IV0, 8'h01, initial a (truncated/zero-extended to W); IV1, 8'h89, initial b; IV2, 8'hFE, initial c.
- K1, 8'h99, round constant for rounds t < MSG_WORDS; K2, 8'hA1, round constant for rounds t >= MSG_WORDS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  block available
- in_ready  out  1  core accepts block
- in_first  in  1  1 = start from IV, 0 = chain from previous digest
- in_msg  in  MSG_WORDS*W  word j at [j*W +: W]
- out_valid  out  1  digest valid
- out_ready  in  1  consumer accepts digest
- out_hash  out  3*W  {c, b, a}; a in [W-1:0]
- busy  out  1  high in ROUND or FINAL

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; out_hash=0; busy=0; chaining register = IV; round counter=0. Reset mid-operation aborts the block; no digest is emitted.
- FSM has four states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load the schedule window with in_msg.
  - Load state and the init register from IV (in_first=1) or the chaining register (in_first=0).
  - Set t=0, go to ROUND.
- ROUND, round t, with w = window[0]:
  - a' = b ^ c
  - b' = (c << SHIFT) truncated to W
  - c' = f + K + w mod 2^W, where f = a ^ b and K = K1 if t < MSG_WORDS; otherwise f = a | b and K = K2.
  - Window shifts down one word; window[MSG_WORDS-1] receives window[MSG_WORDS-3] | (window[MSG_WORDS-9] ^ window[MSG_WORDS-14]). XOR binds first. With defaults this is W[t+16] = W[t+13] | (W[t+7] ^ W[t+2]).
  - When t = ROUNDS-1, go to FINAL; otherwise increment t.
- FINAL:
  - out_hash = {c+init_c, b+init_b, a+init_a}, each sum mod 2^W.
  - Chaining register takes the same value.
  - out_valid=1, go to DONE.
- DONE:
  - out_valid and out_hash are held stable until out_ready.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
  - out_hash keeps its last value until the next FINAL.
- Latency: accept edge to out_valid is ROUNDS+1 cycles. Throughput is one block per ROUNDS+3 cycles without the optional feature.
- in_ready=0 in ROUND, FINAL and DONE; in_msg and in_first are ignored there.
- in_first=0 on the first block after reset chains from IV, so it is identical to in_first=1.
- Counter width is $clog2(ROUNDS+1). There is no wrap: the transition to FINAL happens strictly at ROUNDS-1.

Optional Feature:
- Macro TOY_HASH_B2B_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - Simultaneous out_ready & in_valid completes both handshakes in the same cycle and goes DONE->ROUND directly.
  - The chained value used is the digest just presented.
  - Throughput becomes ROUNDS+2 cycles per block.
- Undefined: in_ready only in IDLE, as above.

Decomposition:
- Package toy_hash_pkg holds:
  - state enum {IDLE, ROUND, FINAL, DONE}
  - default IV0..2, K1, K2 localparams
  - a round-function helper taking (a, b, c, w, phase), returning {c', b', a'}
- One sub-module, toy_hash_sched: MSG_WORDS-entry shift window with load, shift, and window[0] output. Parameters W, MSG_WORDS.

Test Plan:
- ROUNDS=1, in_first=1, all-zero msg -> out_valid exactly 2 cycles after accept, out_hash=24'h1F6978.
- ROUNDS=1, second zero block with in_first=0 after the above -> out_hash=24'hC959EE. Repeat with in_first=1 -> 24'h1F6978 again.
- Defaults (W=8, ROUNDS=32), msg bytes 0x00..0x0F and random blocks -> out_hash matches the C reference model, including schedule words 16..31. Latency is 33 cycles.
- out_ready held low 10 cycles in DONE -> out_valid and out_hash stable. in_valid pulses during ROUND/DONE are not accepted (in_ready=0).
- Reset asserted at round 7 -> next cycle IDLE, in_ready=1, out_valid=0, out_hash=0. A subsequent in_first=0 block produces the IV-based digest.
- TOY_HASH_B2B_EN: in_valid held high with out_ready=1 -> back-to-back blocks every ROUNDS+2 cycles, each chained from the previous digest.
